// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the hazard/forwarding unit
package hazard_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   localparam int FWD_SEL_RF = 0;

   // Select width: one code for the register file plus one per producer stage
   function automatic int sel_width(input int nstage);
      return $clog2(nstage + 1);
   endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - ID/producer bus between the pipeline and the hazard unit
interface hazard_fwd_unit_if
   import hazard_pkg::*;
#(
   parameter int NSRC   = 2,
   parameter int NSTAGE = 3,
   parameter int REGW   = 5
);
   localparam int SELW = sel_width(NSTAGE);

   logic                   flush;
   logic                   id_valid;
   logic [NSRC*REGW-1:0]   id_src;
   logic [NSRC-1:0]        id_src_used;
   logic [NSTAGE-1:0]      prod_wen;
   logic [NSTAGE*REGW-1:0] prod_wn;
   logic                   prod_is_load;
   logic [NSRC*SELW-1:0]   fwd_sel;
   logic                   stall;
   logic                   bubble;

   modport master (
      output flush, id_valid, id_src, id_src_used, prod_wen, prod_wn, prod_is_load,
      input  fwd_sel, stall, bubble
   );

   modport slave (
      input  flush, id_valid, id_src, id_src_used, prod_wen, prod_wn, prod_is_load,
      output fwd_sel, stall, bubble
   );
endinterface

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - one source operand against all producer stages
// Youngest matching stage wins; hit0 flags a stage-0 match for load-use detection.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int REGW   = 5,
   parameter int SELW   = sel_width(NSTAGE)
) (
   input  logic                   id_valid,
   input  logic [REGW-1:0]        src,
   input  logic                   used,
   input  logic [NSTAGE-1:0]      prod_wen,
   input  logic [NSTAGE*REGW-1:0] prod_wn,
   output logic [SELW-1:0]        sel,
   output logic                   hit0
);

   logic [NSTAGE-1:0] hit;

   always_comb begin
      for (int k = 0; k < NSTAGE; k++) begin
         hit[k] = id_valid && used && prod_wen[k] &&
                  (prod_wn[k*REGW +: REGW] == src) && (src != '0);
      end
   end

   always_comb begin
      logic found;
      found = 1'b0;
      sel   = SELW'(FWD_SEL_RF);
      for (int k = 0; k < NSTAGE; k++) begin
         if (!found && hit[k]) begin
            sel   = SELW'(k + 1);
            found = 1'b1;
         end
      end
   end

   assign hit0 = hit[0];

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - operand forwarding select and load-use stall control
// Optional HAZARD_FWD_PERF_EN adds saturating stall/forward event counters.
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int NSRC     = 2,
   parameter int NSTAGE   = 3,
   parameter int REGW     = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   hazard_fwd_unit_if.slave bus
`ifdef HAZARD_FWD_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_fwd_cnt
`endif
);

   localparam int SELW = sel_width(NSTAGE);
   localparam int CW   = $clog2(LOAD_LAT + 1);

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [NSRC*SELW-1:0] fwd_q;
   logic [NSRC*SELW-1:0] sel_comb;
   logic [NSRC*SELW-1:0] fwd_cap;
   logic [NSRC-1:0]      hit0;
   logic                 load_use;
   logic                 stall_c;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_match
      hazard_match #(
         .NSTAGE (NSTAGE),
         .REGW   (REGW),
         .SELW   (SELW)
      ) u_match (
         .id_valid (bus.id_valid),
         .src      (bus.id_src[gi*REGW +: REGW]),
         .used     (bus.id_src_used[gi]),
         .prod_wen (bus.prod_wen),
         .prod_wn  (bus.prod_wn),
         .sel      (sel_comb[gi*SELW +: SELW]),
         .hit0     (hit0[gi])
      );
   end

   assign load_use = bus.prod_is_load && (|hit0);

   always_comb begin
      stall_c = 1'b0;
      if (rst || bus.flush)
         stall_c = 1'b0;
      else if (state == ST_STALL)
         stall_c = 1'b1;
      else
         stall_c = load_use;
   end

   // A stalled ID must not pick up a forward for an instruction that has not issued
   always_comb begin
      fwd_cap = {NSRC{SELW'(FWD_SEL_RF)}};
      if (!bus.flush && bus.id_valid && !stall_c)
         fwd_cap = sel_comb;
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
         fwd_q <= '0;
      end else begin
         fwd_q <= fwd_cap;
         case (state)
            ST_IDLE: begin
               if (load_use && (LOAD_LAT > 1)) begin
                  state <= ST_STALL;
                  cnt   <= CW'(LOAD_LAT - 1);
               end
            end
            ST_STALL: begin
               if (cnt <= CW'(1)) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.fwd_sel = fwd_q;
   assign bus.stall   = stall_c;
   assign bus.bubble  = stall_c;

`ifdef HAZARD_FWD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else begin
         if (stall_c && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if ((|fwd_cap) && (perf_fwd_cnt != '1))
            perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed vector bench for hazard_fwd_unit (LOAD_LAT 1, 2, 3)
module tb_hazard_fwd_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        id_valid;
   logic [9:0]  id_src;
   logic [1:0]  id_src_used;
   logic [2:0]  prod_wen;
   logic [14:0] prod_wn;
   logic        prod_is_load;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   hazard_fwd_unit_if #(.NSRC(2), .NSTAGE(3), .REGW(5)) if1 ();
   hazard_fwd_unit_if #(.NSRC(2), .NSTAGE(3), .REGW(5)) if2 ();
   hazard_fwd_unit_if #(.NSRC(2), .NSTAGE(3), .REGW(5)) if3 ();

   assign if1.flush = flush;        assign if2.flush = flush;        assign if3.flush = flush;
   assign if1.id_valid = id_valid;  assign if2.id_valid = id_valid;  assign if3.id_valid = id_valid;
   assign if1.id_src = id_src;      assign if2.id_src = id_src;      assign if3.id_src = id_src;
   assign if1.id_src_used = id_src_used;
   assign if2.id_src_used = id_src_used;
   assign if3.id_src_used = id_src_used;
   assign if1.prod_wen = prod_wen;  assign if2.prod_wen = prod_wen;  assign if3.prod_wen = prod_wen;
   assign if1.prod_wn = prod_wn;    assign if2.prod_wn = prod_wn;    assign if3.prod_wn = prod_wn;
   assign if1.prod_is_load = prod_is_load;
   assign if2.prod_is_load = prod_is_load;
   assign if3.prod_is_load = prod_is_load;

`ifdef HAZARD_FWD_PERF_EN
   logic [31:0] pst1, pfw1, pst2, pfw2, pst3, pfw3;
`endif

   hazard_fwd_unit #(.NSRC(2), .NSTAGE(3), .REGW(5), .LOAD_LAT(1)) u_dut1 (
      .clk (clk), .rst (rst), .bus (if1.slave)
`ifdef HAZARD_FWD_PERF_EN
      , .perf_stall_cnt (pst1), .perf_fwd_cnt (pfw1)
`endif
   );

   hazard_fwd_unit #(.NSRC(2), .NSTAGE(3), .REGW(5), .LOAD_LAT(2)) u_dut2 (
      .clk (clk), .rst (rst), .bus (if2.slave)
`ifdef HAZARD_FWD_PERF_EN
      , .perf_stall_cnt (pst2), .perf_fwd_cnt (pfw2)
`endif
   );

   hazard_fwd_unit #(.NSRC(2), .NSTAGE(3), .REGW(5), .LOAD_LAT(3)) u_dut3 (
      .clk (clk), .rst (rst), .bus (if3.slave)
`ifdef HAZARD_FWD_PERF_EN
      , .perf_stall_cnt (pst3), .perf_fwd_cnt (pfw3)
`endif
   );

   typedef struct {
      logic       v;
      logic [4:0] s0, s1;
      logic [1:0] u;
      logic [2:0] wen;
      logic [4:0] w0, w1, w2;
      logic       ld;
      logic       e_stall;
      logic [1:0] e_sel0, e_sel1;
   } vec_t;

   vec_t vt[13];

   function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                               input logic [1:0] u, input logic [2:0] wen,
                               input logic [4:0] w0, input logic [4:0] w1, input logic [4:0] w2,
                               input logic ld, input logic e_stall,
                               input logic [1:0] e_sel0, input logic [1:0] e_sel1);
      vec_t r;
      r.v = v; r.s0 = s0; r.s1 = s1; r.u = u; r.wen = wen;
      r.w0 = w0; r.w1 = w1; r.w2 = w2; r.ld = ld;
      r.e_stall = e_stall; r.e_sel0 = e_sel0; r.e_sel1 = e_sel1;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] u, input logic [2:0] wen,
                        input logic [4:0] w0, input logic [4:0] w1, input logic [4:0] w2,
                        input logic ld);
      id_valid     = v;
      id_src       = {s1, s0};
      id_src_used  = u;
      prod_wen     = wen;
      prod_wn      = {w2, w1, w0};
      prod_is_load = ld;
   endtask

   // Ends at a negedge with rst released and idle inputs
   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vt[0]  = mk(1, 5, 0,  2'b11, 3'b010, 0, 5, 0, 0,  0, 2, 0);
      vt[1]  = mk(1, 3, 7,  2'b11, 3'b011, 7, 7, 0, 0,  0, 0, 1);
      vt[2]  = mk(1, 9, 9,  2'b11, 3'b111, 9, 9, 9, 0,  0, 1, 1);
      vt[3]  = mk(1, 4, 0,  2'b01, 3'b100, 0, 0, 4, 0,  0, 3, 0);
      vt[4]  = mk(1, 0, 0,  2'b11, 3'b001, 0, 0, 0, 1,  0, 0, 0);
      vt[5]  = mk(1, 2, 6,  2'b01, 3'b001, 6, 0, 0, 1,  0, 0, 0);
      vt[6]  = mk(1, 6, 0,  2'b01, 3'b001, 6, 0, 0, 1,  1, 0, 0);
      vt[7]  = mk(0, 5, 5,  2'b11, 3'b111, 5, 5, 5, 1,  0, 0, 0);
      vt[8]  = mk(1, 5, 5,  2'b11, 3'b000, 5, 5, 5, 1,  0, 0, 0);
      vt[9]  = mk(1, 8, 0,  2'b01, 3'b110, 0, 8, 8, 0,  0, 2, 0);
      vt[10] = mk(1, 0, 10, 2'b10, 3'b011, 3, 10, 0, 1, 0, 0, 2);
      vt[11] = mk(1, 1, 6,  2'b11, 3'b001, 6, 0, 0, 1,  1, 0, 0);
      vt[12] = mk(1, 6, 0,  2'b01, 3'b001, 6, 0, 0, 0,  0, 1, 0);

      // Reset with a load-use hazard presented: outputs must stay quiet
      rst   = 1'b1;
      flush = 1'b0;
      drive(1, 6, 0, 2'b01, 3'b001, 6, 0, 0, 1);
      @(negedge clk);
      #1;
      check("rst_stall", {31'd0, if1.stall}, 32'd0);
      check("rst_bubble", {31'd0, if3.bubble}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_fwd1", {28'd0, if1.fwd_sel}, 32'd0);
      check("rst_fwd3", {28'd0, if3.fwd_sel}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // LOAD_LAT=1 vector table: stall is same-cycle, fwd_sel one clock later
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vt[i].v, vt[i].s0, vt[i].s1, vt[i].u, vt[i].wen,
               vt[i].w0, vt[i].w1, vt[i].w2, vt[i].ld);
         #1;
         check($sformatf("vec%0d_stall", i), {31'd0, if1.stall}, {31'd0, vt[i].e_stall});
         check($sformatf("vec%0d_bubble", i), {31'd0, if1.bubble}, {31'd0, vt[i].e_stall});
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_sel", i), {28'd0, if1.fwd_sel}, {28'd0, vt[i].e_sel1, vt[i].e_sel0});
      end

      // LOAD_LAT=2 load-use: two stall cycles, then forward from stage 2
      do_reset();
      drive(1, 3, 0, 2'b01, 3'b001, 3, 0, 0, 1);
      #1;
      check("l2_c0_stall", {31'd0, if2.stall}, 32'd1);
      check("l2_c0_bubble", {31'd0, if2.bubble}, 32'd1);
      @(posedge clk);
      #1;
      check("l2_c0_sel", {28'd0, if2.fwd_sel}, 32'd0);
      @(negedge clk);
      drive(1, 3, 0, 2'b01, 3'b010, 0, 3, 0, 0);
      #1;
      check("l2_c1_stall", {31'd0, if2.stall}, 32'd1);
      @(posedge clk);
      #1;
      check("l2_c1_sel", {28'd0, if2.fwd_sel}, 32'd0);
      @(negedge clk);
      drive(1, 3, 0, 2'b01, 3'b100, 0, 0, 3, 0);
      #1;
      check("l2_c2_stall", {31'd0, if2.stall}, 32'd0);
      @(posedge clk);
      #1;
      check("l2_c2_sel", {28'd0, if2.fwd_sel}, 32'd3);

      // LOAD_LAT=3 flush during the second stall cycle
      do_reset();
      drive(1, 3, 0, 2'b01, 3'b001, 3, 0, 0, 1);
      #1;
      check("l3f_c0_stall", {31'd0, if3.stall}, 32'd1);
      @(negedge clk);
      drive(1, 3, 0, 2'b01, 3'b010, 0, 3, 0, 0);
      flush = 1'b1;
      #1;
      check("l3f_flush_stall", {31'd0, if3.stall}, 32'd0);
      check("l3f_flush_bubble", {31'd0, if3.bubble}, 32'd0);
      @(posedge clk);
      #1;
      check("l3f_flush_sel", {28'd0, if3.fwd_sel}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("l3f_idle_stall", {31'd0, if3.stall}, 32'd0);
      @(posedge clk);
      #1;
      check("l3f_after_sel", {28'd0, if3.fwd_sel}, 32'd2);

      // LOAD_LAT=3 full stall: exactly three cycles
      do_reset();
      drive(1, 3, 0, 2'b01, 3'b001, 3, 0, 0, 1);
      #1;
      check("l3_c0_stall", {31'd0, if3.stall}, 32'd1);
      @(negedge clk);
      drive(1, 3, 0, 2'b01, 3'b010, 0, 3, 0, 0);
      #1;
      check("l3_c1_stall", {31'd0, if3.stall}, 32'd1);
      @(negedge clk);
      drive(1, 3, 0, 2'b01, 3'b100, 0, 0, 3, 0);
      #1;
      check("l3_c2_stall", {31'd0, if3.stall}, 32'd1);
      @(negedge clk);
      drive(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
      #1;
      check("l3_c3_stall", {31'd0, if3.stall}, 32'd0);
`ifdef HAZARD_FWD_PERF_EN
      check("perf_stall_3", pst3, 32'd3);
`endif

      // rst mid-stall leaves no residual stall cycles
      @(negedge clk);
      drive(1, 3, 0, 2'b01, 3'b001, 3, 0, 0, 1);
      #1;
      check("l3r_c0_stall", {31'd0, if3.stall}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
      #1;
      check("l3r_rst_stall", {31'd0, if3.stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("l3r_post_stall", {31'd0, if3.stall}, 32'd0);
`ifdef HAZARD_FWD_PERF_EN
      check("perf_stall_rst", pst3, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter NSRC, default 2: source operands per decoded instruction.
REQ-002 Parameter NSTAGE, default 3: producer stages forwarded from; stage 0 = EX/MEM (nearest), stage NSTAGE-1 = oldest.
REQ-003 Parameter REGW, default 5: register index width.
REQ-004 Parameter LOAD_LAT, default 1, legal 1..3: stall cycles needed by a load-use dependency on stage 0.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  pipeline flush, synchronous; kills pending stall and forward selects.
REQ-008 id_valid  in  1  ID stage holds a valid instruction.
REQ-009 id_src  in  NSRC*REGW  packed source register indices, operand 0 in LSBs.
REQ-010 id_src_used  in  NSRC  per-operand "operand actually read" flag.
REQ-011 prod_wen  in  NSTAGE  per-stage register-write enable (valid and writes a register).
REQ-012 prod_wn  in  NSTAGE*REGW  per-stage destination index, stage 0 in LSBs.
REQ-013 prod_is_load  in  1  stage-0 instruction is a load.
REQ-014 fwd_sel  out  NSRC*SELW  registered per-operand select, SELW = clog2(NSTAGE+1); 0 = register file, k+1 = stage k.
REQ-015 stall  out  1  hold PC and ID register.
REQ-016 bubble  out  1  insert NOP into EX this cycle.

Function
REQ-017 Operand i matches stage k when id_valid, id_src_used[i], prod_wen[k], prod_wn[k]==id_src[i] and id_src[i]!=0.
REQ-018 Several matching stages: the lowest k (youngest) wins; identical destinations in several stages never produce an older select.
REQ-019 Load-use hazard: prod_is_load and any used operand matches stage 0.
REQ-020 FSM states IDLE, STALL; counter width clog2(LOAD_LAT+1).
REQ-021 IDLE and hazard: stall=1, bubble=1 combinationally; LOAD_LAT==1 stays IDLE (producer advances), else -> STALL with counter=LOAD_LAT-1.
REQ-022 STALL: stall=1, bubble=1, counter decrements; counter==1 -> IDLE next cycle.
REQ-023 In IDLE, hazard recomputed each cycle against current producer inputs; a new hazard re-enters stall.
REQ-024 fwd_sel updates every clock, latency 1: computed selects when id_valid and not stall, else all zero.
REQ-025 flush has priority over all but rst: next state IDLE, counter 0, fwd_sel 0; stall and bubble forced 0 in flush cycle.
REQ-026 No arithmetic beyond counter; counter never wraps below 0.

Reset
REQ-027 rst on a clock edge: state IDLE, counter 0, fwd_sel 0; stall and bubble 0 while rst high.
REQ-028 rst mid-STALL abandons the stall with no residual cycles.

Configuration
REQ-029 Macro HAZARD_FWD_PERF_EN defined: add outputs perf_stall_cnt (32 b) and perf_fwd_cnt (32 b), saturating, cleared by rst; perf_stall_cnt +1 per stall cycle, perf_fwd_cnt +1 per cycle with any nonzero fwd_sel capture.
REQ-030 Macro undefined: those ports and counters absent; other behaviour identical.

Structure
REQ-031 Package hazard_pkg: FSM state enum, FWD_SEL_RF constant (0), SELW derivation function.
REQ-032 Sub-module hazard_match: one operand vs NSTAGE producers -> priority-encoded select and stage-0 hit; instantiated NSRC times.

Verification
REQ-033 Stage 1 writes r5, ID src0=r5 -> next cycle fwd_sel[0]=2, stall=0.
REQ-034 Stages 0 and 1 both write r7, src1=r7, no load -> fwd_sel[1]=1.
REQ-035 LOAD_LAT=2, stage-0 load to r3, src0=r3 -> stall/bubble 2 cycles, fwd_sel 0 during stall, then forward from advanced stage.
REQ-036 Stage 0 writes r0, src0=r0 -> fwd_sel[0]=0, no stall; src1 matching with id_src_used[1]=0 -> no stall.
REQ-037 LOAD_LAT=3, flush in 2nd stall cycle -> stall=0 same cycle, state IDLE, fwd_sel 0 next cycle.
REQ-038 With HAZARD_FWD_PERF_EN, 3 stall cycles then rst -> perf_stall_cnt reads 3, then 0.
